register_pipe: RTL

Parametrised successor to the single-stage enabled register. It is a DEPTH-stage, WIDTH-bit delay line with a programmable reset/clear value. Every stage carries a valid bit, all stages stall together under a shared enable, and the block keeps a running occupancy count. It is the standard primitive for retiming datapath values across pipeline cuts in generated designs. With DEPTH=1 and valid ignored, it behaves exactly like the legacy register.

---
 rtl/register_pipe_if.sv | 26 ++
 rtl/register_pipe.sv | 55 +++++
 2 files changed

// File: rtl/register_pipe_if.sv
// Data/valid/control bundle for register_pipe.
// The master drives the stage-0 inputs and controls; the slave returns the last stage and the occupancy count.
interface register_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] a;
  logic             valid_in;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] y;
  logic             valid_out;
  logic [CW-1:0]    count;

  modport master (
    output a, valid_in, en, clear,
    input  y, valid_out, count
  );

  modport slave (
    input  a, valid_in, en, clear,
    output y, valid_out, count
  );
endinterface

// File: rtl/register_pipe.sv
// DEPTH-stage WIDTH-bit delay line with per-stage valid bits, shared stall and occupancy count.
// With DEPTH=1 and valid ignored it is the plain enabled register with a reset value.
module register_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1,
  parameter logic [63:0] INIT  = 64'd3
) (
  input  logic           clock,
  input  logic           reset,
  register_pipe_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  if (DEPTH == 0) begin : g_bad_depth
    $error("register_pipe: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;

  // Occupancy moves only when an entry enters without one leaving, or vice versa.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.valid_in && !r_vld[DEPTH-1]) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!bus.valid_in && r_vld[DEPTH-1]) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= INIT_W;
      end
      r_vld   <= '0;
      r_count <= '0;
    end else if (bus.en) begin
      r_data[0] <= bus.a;
      r_vld[0]  <= bus.valid_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_count <= w_count_nxt;
    end
  end

  assign bus.y         = r_data[DEPTH-1];
  assign bus.valid_out = r_vld[DEPTH-1];
  assign bus.count     = r_count;
endmodule
